// File: rtl/calc_alu_pkg.sv
// Shared opcodes, status codes and state encoding for the sequential calculator ALU.
package calc_alu_pkg;

    localparam int unsigned OP_W   = 4;
    localparam int unsigned CODE_W = 3;

    // One-hot active-low opcodes, as driven by the key decoder
    localparam logic [OP_W-1:0] OP_ADD  = 4'b1110;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b1101;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b1011;
    localparam logic [OP_W-1:0] OP_DIV  = 4'b0111;
    localparam logic [OP_W-1:0] OP_PASS = 4'b1111;

    // Status codes consumed by the display driver
    localparam logic [CODE_W-1:0] CODE_P   = 3'd0;
    localparam logic [CODE_W-1:0] CODE_M   = 3'd1;
    localparam logic [CODE_W-1:0] CODE_D0  = 3'd2;
    localparam logic [CODE_W-1:0] CODE_OVF = 3'd3;
    localparam logic [CODE_W-1:0] CODE_D   = 3'd4;
    localparam logic [CODE_W-1:0] CODE_ERR = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_t;

endpackage

// File: rtl/calc_alu_seq_if.sv
// Operand/opcode/handshake bundle between the key decoder, the ALU and the display.
interface calc_alu_seq_if #(
    parameter int unsigned WIDTH   = 11,
    parameter int unsigned ARIF    = 4,
    parameter int unsigned CONTROL = 3
);

    logic [WIDTH-1:0]   in_numb;
    logic               load_a;
    logic               load_b;
    logic [ARIF-1:0]    arif;
    logic               start;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic [CONTROL-1:0] control;

    modport master (
        output in_numb, load_a, load_b, arif, start,
        input  busy, done, result, control
    );

    modport slave (
        input  in_numb, load_a, load_b, arif, start,
        output busy, done, result, control
    );

endinterface

// File: rtl/calc_div_restoring.sv
// Iterative restoring divider, one quotient bit per cycle.
// The first bit is produced on the start edge itself, so done pulses
// DIV_W-1 cycles after start with the full quotient in place.
module calc_div_restoring #(
    parameter int unsigned DIV_W = 18,
    parameter int unsigned WIDTH = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIV_W-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [DIV_W-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(DIV_W);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_W - 1);

    logic [WIDTH-1:0] rem_q,  rem_d;
    logic [DIV_W-1:0] quo_q,  quo_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             run_q,  run_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] src_rem_c;
    logic [DIV_W-1:0] src_quo_c;
    logic [WIDTH-1:0] src_dvsr_c;
    logic [WIDTH:0]   trial_c;
    logic [WIDTH-1:0] step_rem_c;
    logic             qbit_c;

    // One restoring step, fed from the inputs on start or from the registers otherwise
    always_comb begin
        src_rem_c  = start ? '0 : rem_q;
        src_quo_c  = start ? dividend : quo_q;
        src_dvsr_c = start ? divisor : dvsr_q;
        trial_c    = {src_rem_c, src_quo_c[DIV_W-1]};
        qbit_c     = 1'b0;
        step_rem_c = trial_c[WIDTH-1:0];
        if (trial_c >= {1'b0, src_dvsr_c}) begin
            qbit_c     = 1'b1;
            step_rem_c = WIDTH'(trial_c - {1'b0, src_dvsr_c});
        end
    end

    // Iteration control and register update
    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvsr_d = dvsr_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = step_rem_c;
            quo_d  = {src_quo_c[DIV_W-2:0], qbit_c};
            dvsr_d = divisor;
            cnt_d  = CNT_W'(1);
            run_d  = 1'b1;
        end else if (run_q) begin
            rem_d = step_rem_c;
            quo_d = {src_quo_c[DIV_W-2:0], qbit_c};
            if (cnt_q == LAST) begin
                run_d  = 1'b0;
                done_d = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/calc_alu_seq.sv
// Multi-cycle calculator ALU: add/sub in one cycle, shift-add multiply,
// scaled restoring divide, with overflow and invalid-opcode status.
module calc_alu_seq
    import calc_alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 11,
    parameter int unsigned SCALE   = 100,
    parameter int unsigned ARIF    = 4,
    parameter int unsigned CONTROL = 3
) (
    input  logic          clk_ALU,
    input  logic          rst_ALU,
    calc_alu_seq_if.slave bus
);

    localparam int unsigned DIV_W  = WIDTH + $clog2(SCALE);
    localparam int unsigned ACC_W  = 2 * WIDTH;
    localparam int unsigned MCNT_W = $clog2(WIDTH + 1);
    localparam int unsigned SC_W   = $clog2(SCALE) + 1;
    localparam logic [31:0] SCALE_BITS = 32'(SCALE);

    localparam logic [ARIF-1:0] A_ADD  = ARIF'(OP_ADD);
    localparam logic [ARIF-1:0] A_SUB  = ARIF'(OP_SUB);
    localparam logic [ARIF-1:0] A_MUL  = ARIF'(OP_MUL);
    localparam logic [ARIF-1:0] A_DIV  = ARIF'(OP_DIV);
    localparam logic [ARIF-1:0] A_PASS = ARIF'(OP_PASS);

    localparam logic [CONTROL-1:0] C_P   = CONTROL'(CODE_P);
    localparam logic [CONTROL-1:0] C_M   = CONTROL'(CODE_M);
    localparam logic [CONTROL-1:0] C_D0  = CONTROL'(CODE_D0);
    localparam logic [CONTROL-1:0] C_OVF = CONTROL'(CODE_OVF);
    localparam logic [CONTROL-1:0] C_D   = CONTROL'(CODE_D);
    localparam logic [CONTROL-1:0] C_ERR = CONTROL'(CODE_ERR);

    localparam logic [MCNT_W-1:0] MUL_LAST = MCNT_W'(WIDTH - 1);

    alu_state_t         state_q,   state_d;
    logic [WIDTH-1:0]   a_q,       a_d;
    logic [WIDTH-1:0]   b_q,       b_d;
    logic [WIDTH-1:0]   result_q,  result_d;
    logic [CONTROL-1:0] control_q, control_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic [ACC_W-1:0]   acc_q,     acc_d;
    logic [ACC_W-1:0]   mcand_q,   mcand_d;
    logic [WIDTH-1:0]   mplier_q,  mplier_d;
    logic [MCNT_W-1:0]  mcnt_q,    mcnt_d;

    logic [WIDTH:0]     sum_c;
    logic [ACC_W-1:0]   mul_acc_c;
    logic [DIV_W-1:0]   dividend_c;
    logic               div_start_c;
    logic               div_done;
    logic [DIV_W-1:0]   div_quotient;

    // A*SCALE as a constant shift-add over the set bits of SCALE
    always_comb begin
        dividend_c = '0;
        for (int i = 0; i < SC_W; i++) begin
            if (SCALE_BITS[i]) begin
                dividend_c = dividend_c + (DIV_W'(a_q) << i);
            end
        end
    end

    // Adder and one multiply step
    always_comb begin
        sum_c     = {1'b0, a_q} + {1'b0, b_q};
        mul_acc_c = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    end

    calc_div_restoring #(
        .DIV_W (DIV_W),
        .WIDTH (WIDTH)
    ) u_div (
        .clk      (clk_ALU),
        .rst      (rst_ALU),
        .start    (div_start_c),
        .dividend (dividend_c),
        .divisor  (b_q),
        .done     (div_done),
        .quotient (div_quotient)
    );

    // Next-state, operand loads and result/status computation
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        control_d   = control_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        mcnt_d      = mcnt_q;
        div_start_c = 1'b0;

        if (!busy_q) begin
            if (bus.load_a) a_d = bus.in_numb;
            if (bus.load_b) b_d = bus.in_numb;
        end

        unique case (state_q)
            IDLE: begin
                if (bus.arif == A_PASS) begin
                    result_d  = bus.in_numb;
                    control_d = C_P;
                end
                if (bus.start) begin
                    state_d = DONE;
                    if (bus.arif == A_ADD) begin
                        if (sum_c[WIDTH]) begin
                            result_d  = '1;
                            control_d = C_OVF;
                        end else begin
                            result_d  = sum_c[WIDTH-1:0];
                            control_d = C_P;
                        end
                    end else if (bus.arif == A_SUB) begin
                        if (a_q < b_q) begin
                            result_d  = b_q - a_q;
                            control_d = C_M;
                        end else begin
                            result_d  = a_q - b_q;
                            control_d = C_P;
                        end
                    end else if (bus.arif == A_MUL) begin
                        state_d  = MUL;
                        acc_d    = '0;
                        mcand_d  = ACC_W'(a_q);
                        mplier_d = b_q;
                        mcnt_d   = '0;
                    end else if (bus.arif == A_DIV) begin
                        if (b_q == '0) begin
                            control_d = C_D0;
                        end else begin
                            state_d     = DIV;
                            div_start_c = 1'b1;
                        end
                    end else if (bus.arif == A_PASS) begin
                        result_d  = bus.in_numb;
                        control_d = C_P;
                    end else begin
                        result_d  = '0;
                        control_d = C_ERR;
                    end
                end
            end
            MUL: begin
                acc_d    = mul_acc_c;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                mcnt_d   = mcnt_q + MCNT_W'(1);
                if (mcnt_q == MUL_LAST) begin
                    state_d = DONE;
                    if (mul_acc_c[ACC_W-1:WIDTH] != '0) begin
                        result_d  = '1;
                        control_d = C_OVF;
                    end else begin
                        result_d  = mul_acc_c[WIDTH-1:0];
                        control_d = C_P;
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d = DONE;
                    if (div_quotient[DIV_W-1:WIDTH] != '0) begin
                        result_d  = '1;
                        control_d = C_OVF;
                    end else begin
                        result_d  = div_quotient[WIDTH-1:0];
                        control_d = C_D;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == MUL) || (state_d == DIV);
        done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge clk_ALU) begin
        if (rst_ALU) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            control_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            mcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            control_q <= control_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            mcnt_q    <= mcnt_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.result  = result_q;
    assign bus.control = control_q;

endmodule

// File: tb/tb_calc_alu_seq.sv
// Directed bench for calc_alu_seq with hand-computed expected values.
module tb_calc_alu_seq;
    import calc_alu_pkg::*;

    localparam int unsigned WIDTH   = 11;
    localparam int unsigned ARIF    = 4;
    localparam int unsigned CONTROL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned lat;
    int unsigned pulses;

    calc_alu_seq_if #(.WIDTH(WIDTH), .ARIF(ARIF), .CONTROL(CONTROL)) bus ();

    calc_alu_seq #(
        .WIDTH   (WIDTH),
        .SCALE   (100),
        .ARIF    (ARIF),
        .CONTROL (CONTROL)
    ) dut (
        .clk_ALU (clk),
        .rst_ALU (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it differs
    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic load_ab(input int unsigned a, input int unsigned b);
        @(negedge clk);
        bus.in_numb = WIDTH'(a);
        bus.load_a  = 1'b1;
        @(negedge clk);
        bus.load_a  = 1'b0;
        bus.in_numb = WIDTH'(b);
        bus.load_b  = 1'b1;
        @(negedge clk);
        bus.load_b  = 1'b0;
    endtask

    task automatic load_one(input bit to_b, input int unsigned v);
        @(negedge clk);
        bus.in_numb = WIDTH'(v);
        if (to_b) bus.load_b = 1'b1;
        else      bus.load_a = 1'b1;
        @(negedge clk);
        bus.load_a = 1'b0;
        bus.load_b = 1'b0;
    endtask

    // Start one op, measure latency and busy cycles, then check the outputs
    task automatic run_op(input string tag, input logic [ARIF-1:0] op,
                          input int unsigned exp_lat, input int unsigned exp_res,
                          input int unsigned exp_ctl);
        int unsigned l;
        int unsigned bcnt;
        @(negedge clk);
        bus.arif  = op;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.arif  = OP_ADD;
        l    = 1;
        bcnt = 0;
        while (!bus.done && l < 40) begin
            if (bus.busy) bcnt++;
            @(negedge clk);
            l++;
        end
        chk({tag, "_lat"}, l, exp_lat);
        chk({tag, "_busy"}, bcnt, exp_lat - 1);
        chk({tag, "_res"}, 32'(bus.result), exp_res);
        chk({tag, "_ctl"}, 32'(bus.control), exp_ctl);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(bus.done), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_numb = '0;
        bus.load_a  = 1'b0;
        bus.load_b  = 1'b0;
        bus.arif    = OP_ADD;
        bus.start   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_res",  32'(bus.result), 0);
        chk("rst_ctl",  32'(bus.control), 0);

        load_ab(1500, 600);
        run_op("add_ovf", OP_ADD, 1, 2047, 3);

        load_ab(5, 9);
        run_op("sub_neg", OP_SUB, 1, 4, 1);
        load_ab(9, 5);
        run_op("sub_pos", OP_SUB, 1, 4, 0);

        load_ab(45, 45);
        run_op("mul_ok", OP_MUL, 12, 2025, 0);
        load_ab(46, 46);
        run_op("mul_ovf", OP_MUL, 12, 2047, 3);

        repeat (3) @(negedge clk);
        chk("hold_res", 32'(bus.result), 2047);
        chk("hold_ctl", 32'(bus.control), 3);

        load_ab(7, 3);
        run_op("div", OP_DIV, 19, 233, 4);

        // Loads and repeated start while the divider runs must be ignored
        @(negedge clk);
        bus.arif  = OP_DIV;
        bus.start = 1'b1;
        @(negedge clk);
        bus.in_numb = 11'd99;
        bus.load_a  = 1'b1;
        lat = 1;
        while (!bus.done && lat < 40) begin
            if (lat == 4) begin
                bus.start  = 1'b0;
                bus.load_a = 1'b0;
                bus.arif   = OP_ADD;
            end
            @(negedge clk);
            lat++;
        end
        chk("div_busy_lat", lat, 19);
        chk("div_busy_res", 32'(bus.result), 233);
        chk("div_busy_ctl", 32'(bus.control), 4);
        run_op("a_kept", OP_ADD, 1, 10, 0);

        load_ab(5, 0);
        run_op("div0", OP_DIV, 1, 10, 2);

        // Reset in the middle of a divide
        load_ab(7, 3);
        @(negedge clk);
        bus.arif  = OP_DIV;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.arif  = OP_ADD;
        repeat (4) @(negedge clk);
        chk("mid_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy", 32'(bus.busy), 0);
        chk("mrst_res",  32'(bus.result), 0);
        chk("mrst_ctl",  32'(bus.control), 0);
        chk("mrst_done", 32'(bus.done), 0);
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        chk("mrst_nodone", pulses, 0);
        run_op("mrst_b0", OP_DIV, 1, 0, 2);
        load_one(1'b1, 5);
        run_op("mrst_a0", OP_SUB, 1, 5, 1);

        // Passthrough sweep: result follows in_numb one cycle later
        bus.arif = OP_PASS;
        for (int v = 0; v < 2048; v++) begin
            @(negedge clk);
            if (v > 0) chk("pass", 32'(bus.result), 32'(v - 1));
            bus.in_numb = WIDTH'(v);
        end
        @(negedge clk);
        chk("pass_last", 32'(bus.result), 2047);
        chk("pass_ctl",  32'(bus.control), 0);

        run_op("invalid", 4'b0000, 1, 0, 5);

        // Simultaneous loads take the same value
        @(negedge clk);
        bus.in_numb = 11'd12;
        bus.load_a  = 1'b1;
        bus.load_b  = 1'b1;
        @(negedge clk);
        bus.load_a  = 1'b0;
        bus.load_b  = 1'b0;
        run_op("load_both", OP_ADD, 1, 24, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_alu_seq.md
Name: calc_alu_seq

Overview:
Multi-cycle successor to the calculator's single-cycle arithmetic unit. It latches two operands from the switch input under key control and runs add, subtract, multiply and scaled divide on a start/busy/done handshake. Multiply and divide are iterative (shift-add and restoring), which replaces combinational `*` and `/`. Width and division scale are parametrised, and the block adds overflow and invalid-opcode reporting. It sits between the input/key decoder and the display driver, which consumes `result` and `control`.

Parameters:
WIDTH, 11, operand and result width
SCALE, 100, divide pre-multiplier (fixed-point display, two decimals)
ARIF, 4, opcode width (one-hot active-low, as in the calculator)
CONTROL, 3, status code width
DIV_W, WIDTH+$clog2(SCALE), dividend width for scaled divide (derived; do not override)

Ports:
clk_ALU  in  1  system clock
rst_ALU  in  1  synchronous active-high reset
in_numb  in  WIDTH  operand value from switches
load_a  in  1  latch in_numb into operand A (key 1)
load_b  in  1  latch in_numb into operand B (key 2)
arif  in  ARIF  opcode: 1110 add, 1101 sub, 1011 mul, 0111 div, 1111 passthrough
start  in  1  begin operation (level sampled on clk_ALU edge)
busy  out  1  operation in progress
done  out  1  one-cycle pulse, result/control valid
result  out  WIDTH  result magnitude
control  out  CONTROL  status code

Behaviour:
- Single clock, clk_ALU; rst_ALU is synchronous, active-high.
- Reset, including mid-operation: state=IDLE, A=B=0, result=0, control=0, busy=0, done=0. Any partial product or quotient is discarded.
- Status codes: 0 positive, 1 negative (sub), 2 divide-by-zero, 3 overflow (result saturated to all ones), 4 scaled quotient, 5 invalid opcode.
- Loads: accepted only when busy=0.
  - load_a and load_b together: both registers take in_numb.
  - Loads while busy are ignored.
- States: IDLE, MUL, DIV, DONE.
- IDLE behaviour:
  - With arif=1111: result<=in_numb every cycle, control<=0 (live display).
  - start=1: snapshot A, B and opcode; busy<=1 on the same edge, except for single-cycle ops.
  - Operand snapshot uses the pre-edge A/B. A load in the same cycle still updates A/B, but for the next operation only.
- Single-cycle ops (add, sub, passthrough, div-by-zero, invalid):
  - Result computed at the start edge; transition to DONE.
  - done=1 in the following cycle (latency 1); busy stays 0.
- Add: {carry,sum}=A+B. If carry=1: result=all ones, control=3; else sum, control=0.
- Sub: if A<B: result=B-A, control=1; else A-B, control=0.
- Mul:
  - WIDTH iterations of shift-add on a 2*WIDTH accumulator, one bit per cycle.
  - done asserts WIDTH+1 cycles after the start edge.
  - If the upper WIDTH bits are non-zero: result=all ones, control=3; else low bits, control=0.
- Div:
  - B=0: single-cycle op, result unchanged, control=2.
  - Otherwise dividend=A*SCALE (DIV_W bits, computed as constant shift-add at start) and DIV_W restoring iterations.
  - done asserts DIV_W+1 cycles after the start edge.
  - Quotient ≥2^WIDTH: result=all ones, control=3; else quotient, control=4.
  - Remainder is discarded (truncation toward zero).
- Other arif values with start: invalid op, result=0, control=5.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- result and control hold until the next start, except in passthrough IDLE.
- start while busy is ignored; it is not queued.
- start asserted on the DONE cycle is ignored; it must be re-presented in IDLE.

Decomposition:
- Package calc_alu_pkg:
  - opcode constants OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_PASS
  - status constants CODE_P, CODE_M, CODE_D0, CODE_OVF, CODE_D, CODE_ERR
  - state enum alu_state_t
- Sub-module calc_div_restoring:
  - Parametrised on DIV_W and WIDTH.
  - Ports: start, dividend, divisor → done, quotient.
  - Iterative restoring divider, one quotient bit per cycle.
- Multiply stays inline in the top.

Test Plan:
- A=1500, B=600, add, start → done at latency 1, result=2047, control=3.
- A=5, B=9, sub → result=4, control=1; then A=9, B=5 → result=4, control=0.
- A=45, B=45, mul → busy for 11 cycles, done exactly 12 cycles after start, result=2025, control=0. A=46, B=46 → result=2047, control=3.
- A=7, B=3, div → done 19 cycles after start, result=233, control=4. A=5, B=0 → done at latency 1, control=2, result unchanged.
- Start div (A=7, B=3), pulse load_a with in_numb=99 and repeat start while busy → loads and start ignored, result=233, A still 7. Then rst_ALU mid-div → next cycle busy=0, result=0, control=0, A=B=0, no done pulse.
- arif=1111, sweep in_numb 0→2047 → result tracks with one-cycle lag, control=0. arif=0000 with start → result=0, control=5.
